// File: rtl/paint_pkg.sv
// Shared paint-path definitions: screen geometry, pixel format, brush_writer
// states and the {r,g,b} pixel packing used by both drawing and scan-out.
package paint_pkg;

  localparam int H_RES   = 320;
  localparam int V_RES   = 240;
  localparam int COLOR_W = 3;
  localparam int PIXEL_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } brush_state_t;

  // Raster position plus a flag meaning "no successor pixel exists".
  typedef struct packed {
    logic       last;
    logic [7:0] y;
    logic [8:0] x;
  } brush_pos_t;

  function automatic logic [PIXEL_W-1:0] pack_rgb(input logic [COLOR_W-1:0] r,
                                                  input logic [COLOR_W-1:0] g,
                                                  input logic [COLOR_W-1:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/brush_bounds.sv
// Combinational clipping of a square brush (centre + side-1) to the screen,
// yielding the inclusive pixel rectangle and an empty flag.
module brush_bounds
  import paint_pkg::*;
#(
  parameter int H_RES = paint_pkg::H_RES,
  parameter int V_RES = paint_pkg::V_RES
) (
  input  logic [8:0] cx,
  input  logic [7:0] cy,
  input  logic [2:0] size,
  output logic [8:0] x0,
  output logic [8:0] x1,
  output logic [7:0] y0,
  output logic [7:0] y1,
  output logic       empty
);

  logic [2:0] half;
  logic [9:0] x_end;
  logic [8:0] y_end;

  assign half = size >> 1;

  // Far edge is centre-half+side-1, rearranged so it never goes negative.
  assign x_end = {1'b0, cx} + {7'd0, size} - {7'd0, half};
  assign y_end = {1'b0, cy} + {6'd0, size} - {6'd0, half};

  assign x0 = (cx < {6'd0, half}) ? 9'd0 : cx - {6'd0, half};
  assign y0 = (cy < {5'd0, half}) ? 8'd0 : cy - {5'd0, half};
  assign x1 = (x_end > 10'(H_RES - 1)) ? 9'(H_RES - 1) : x_end[8:0];
  assign y1 = (y_end > 9'(V_RES - 1))  ? 8'(V_RES - 1) : y_end[7:0];

  assign empty = ({1'b0, cx} >= 10'(H_RES)) || ({1'b0, cy} >= 9'(V_RES));

endmodule

// File: rtl/brush_writer.sv
// Paint-stroke write engine: latches colour/cursor on pintar and streams the
// clipped brush square to the frame buffer. BRUSH_ROUND_EN drops the 4 corners.
module brush_writer
  import paint_pkg::*;
#(
  parameter int H_RES  = paint_pkg::H_RES,
  parameter int V_RES  = paint_pkg::V_RES,
  parameter int ADDR_W = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pintar,
  input  logic [8:0]         cursor_x,
  input  logic [7:0]         cursor_y,
  input  logic [2:0]         brush_size,
  input  logic [COLOR_W-1:0] r_escrita_memoria,
  input  logic [COLOR_W-1:0] g_escrita_memoria,
  input  logic [COLOR_W-1:0] b_escrita_memoria,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [PIXEL_W-1:0] mem_data,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic               busy,
  output logic               done
);

`ifdef BRUSH_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  brush_state_t       state_reg;
  logic [8:0]         cx_reg, x0_reg, x1_reg, x_reg;
  logic [7:0]         cy_reg, y1_reg, y_reg;
  logic [2:0]         size_reg;
  logic [PIXEL_W-1:0] color_reg, mem_data_reg;
  logic [ADDR_W-1:0]  mem_addr_reg;
  logic               mem_we_reg, busy_reg, done_reg;

  logic [8:0] b_x0, b_x1;
  logic [7:0] b_y0, b_y1;
  logic       b_empty;
  logic [2:0] half;

  brush_pos_t s1_pos, nxt_pos, t1_pos, strt_pos;

  brush_bounds #(.H_RES(H_RES), .V_RES(V_RES)) u_bounds (
    .cx(cx_reg), .cy(cy_reg), .size(size_reg),
    .x0(b_x0), .x1(b_x1), .y0(b_y0), .y1(b_y1), .empty(b_empty)
  );

  assign half = size_reg >> 1;

  function automatic brush_pos_t step(input logic [8:0] x, input logic [7:0] y,
                                      input logic [8:0] lx0, input logic [8:0] lx1,
                                      input logic [7:0] ly1);
    brush_pos_t p;
    if (x == lx1) begin
      p.last = (y == ly1);
      p.y    = y + 8'd1;
      p.x    = lx0;
    end else begin
      p.last = 1'b0;
      p.y    = y;
      p.x    = x + 9'd1;
    end
    return p;
  endfunction

  // Corner of the unclipped square; compared as x+half so nothing goes negative.
  function automatic logic is_corner(input logic [8:0] x, input logic [7:0] y);
    logic col_edge, row_edge;
    col_edge = ({1'b0, x} + {7'd0, half} == {1'b0, cx_reg}) ||
               ({1'b0, x} + {7'd0, half} == {1'b0, cx_reg} + {7'd0, size_reg});
    row_edge = ({1'b0, y} + {6'd0, half} == {1'b0, cy_reg}) ||
               ({1'b0, y} + {6'd0, half} == {1'b0, cy_reg} + {6'd0, size_reg});
    return ROUND_EN && (size_reg >= 3'd2) && col_edge && row_edge;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [8:0] x, input logic [7:0] y);
    return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  // Successor pixels; at most one corner can lie between two kept pixels.
  always_comb begin
    s1_pos  = step(x_reg, y_reg, x0_reg, x1_reg, y1_reg);
    nxt_pos = s1_pos;
    if (!s1_pos.last && is_corner(s1_pos.x, s1_pos.y))
      nxt_pos = step(s1_pos.x, s1_pos.y, x0_reg, x1_reg, y1_reg);
    t1_pos   = step(b_x0, b_y0, b_x0, b_x1, b_y1);
    strt_pos = '{last: 1'b0, y: b_y0, x: b_x0};
    if (is_corner(b_x0, b_y0))
      strt_pos = t1_pos;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cx_reg       <= '0;
      cy_reg       <= '0;
      size_reg     <= '0;
      color_reg    <= '0;
      x0_reg       <= '0;
      x1_reg       <= '0;
      y1_reg       <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
      mem_we_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (pintar) begin
            cx_reg    <= cursor_x;
            cy_reg    <= cursor_y;
            size_reg  <= brush_size;
            color_reg <= pack_rgb(r_escrita_memoria, g_escrita_memoria, b_escrita_memoria);
            busy_reg  <= 1'b1;
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          x0_reg       <= b_x0;
          x1_reg       <= b_x1;
          y1_reg       <= b_y1;
          mem_data_reg <= color_reg;
          if (b_empty || strt_pos.last) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            x_reg        <= strt_pos.x;
            y_reg        <= strt_pos.y;
            mem_addr_reg <= addr_of(strt_pos.x, strt_pos.y);
            mem_we_reg   <= 1'b1;
            state_reg    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            if (nxt_pos.last) begin
              mem_we_reg <= 1'b0;
              done_reg   <= 1'b1;
              state_reg  <= ST_DONE;
            end else begin
              x_reg        <= nxt_pos.x;
              y_reg        <= nxt_pos.y;
              mem_addr_reg <= addr_of(nxt_pos.x, nxt_pos.y);
            end
          end
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr = mem_addr_reg;
  assign mem_data = mem_data_reg;
  assign mem_we   = mem_we_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_brush_writer.sv
// Directed bench for brush_writer with hand-computed addresses, colours and
// cycle positions; define BRUSH_ROUND_EN for the rounded-footprint build.
module tb_brush_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pintar;
  logic [8:0]  cursor_x;
  logic [7:0]  cursor_y;
  logic [2:0]  brush_size;
  logic [2:0]  r_in, g_in, b_in;
  logic [16:0] mem_addr;
  logic [8:0]  mem_data;
  logic        mem_we;
  logic        mem_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] got_addr[$];
  logic [8:0]  got_data[$];
  int          got_cyc[$];
  int          done_rel;
  int          done_cnt;
  int          exp_q[$];

  always #5 clk = ~clk;

  brush_writer dut (
    .clk(clk), .rst_n(rst_n), .pintar(pintar),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .brush_size(brush_size),
    .r_escrita_memoria(r_in), .g_escrita_memoria(g_in), .b_escrita_memoria(b_in),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_ready(mem_ready), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one stroke; cycle n counts from 1 = LOAD after the pintar edge.
  task automatic run_stroke(input string tag, input logic [2:0] size,
                            input logic [8:0] x, input logic [7:0] y,
                            input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                            input int stall_at, input int stall_len, input bit mid_change);
    int rel, stall_left, post;
    logic [16:0] hold_addr;
    logic [8:0]  hold_data;
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_rel   = -1;
    done_cnt   = 0;
    stall_left = stall_len;
    post       = 0;
    rel        = 0;
    hold_addr  = '0;
    hold_data  = '0;
    @(negedge clk);
    brush_size = size; cursor_x = x; cursor_y = y;
    r_in = r; g_in = g; b_in = b;
    pintar = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 80 && post < 4; k++) begin
      @(negedge clk);
      rel++;
      if (rel == 1 || rel == 6) pintar = 1'b0;
      if (mid_change && rel == 3) begin
        r_in = 3'd7; g_in = 3'd7; b_in = 3'd7; cursor_x = 9'd5; pintar = 1'b1;
      end
      if (mem_we && got_addr.size() == stall_at && stall_left > 0) begin
        if (stall_left == stall_len) begin
          hold_addr = mem_addr;
          hold_data = mem_data;
        end else begin
          check({tag, "_hold_addr"}, mem_addr, hold_addr);
          check({tag, "_hold_data"}, mem_data, hold_data);
        end
        mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem_ready = 1'b1;
      end
      if (mem_we && mem_ready) begin
        got_addr.push_back(mem_addr);
        got_data.push_back(mem_data);
        got_cyc.push_back(rel);
      end
      if (done) begin
        done_cnt++;
        if (done_rel < 0) begin
          done_rel = rel;
          check({tag, "_busy_at_done"}, busy, 1);
        end
      end
      if (done_rel >= 0 && rel > done_rel) begin
        post++;
        if (post == 1) check({tag, "_busy_after"}, busy, 0);
      end
    end
    mem_ready = 1'b1;
    if (done_rel < 0) check({tag, "_done_seen"}, 0, 1);
    check({tag, "_done_pulses"}, done_cnt, 1);
    $display("stroke %s: writes=%0d done_cycle=%0d", tag, got_addr.size(), done_rel);
  endtask

  task automatic check_stroke(input string tag, input int exp[$], input logic [8:0] colour,
                              input int stall_at, input int stall_len);
    check({tag, "_count"}, got_addr.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp[i]);
      check($sformatf("%s_data%0d", tag, i), got_data[i], colour);
      check($sformatf("%s_cyc%0d", tag, i), got_cyc[i],
            2 + i + ((stall_at >= 0 && i >= stall_at) ? stall_len : 0));
    end
    check({tag, "_done_cyc"}, done_rel, 2 + exp.size() + stall_len);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; pintar = 1'b0; mem_ready = 1'b1;
    cursor_x = '0; cursor_y = '0; brush_size = '0;
    r_in = '0; g_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_stroke("single", 3'd0, 9'd10, 8'd20, 3'd7, 3'd0, 3'd3, -1, 0, 1'b0);
    exp_q = '{6410};
    check_stroke("single", exp_q, 9'h1C3, -1, 0);

`ifdef BRUSH_ROUND_EN
    exp_q = '{15780, 16099, 16100, 16101, 16420};
`else
    exp_q = '{15779, 15780, 15781, 16099, 16100, 16101, 16419, 16420, 16421};
`endif
    run_stroke("sq3", 3'd2, 9'd100, 8'd50, 3'd2, 3'd5, 3'd1, -1, 0, 1'b0);
    check_stroke("sq3", exp_q, 9'h0A9, -1, 0);

    run_stroke("stall", 3'd2, 9'd100, 8'd50, 3'd2, 3'd5, 3'd1, 3, 5, 1'b0);
    check_stroke("stall", exp_q, 9'h0A9, 3, 5);

    run_stroke("midchg", 3'd2, 9'd100, 8'd50, 3'd1, 3'd2, 3'd3, -1, 0, 1'b1);
    check_stroke("midchg", exp_q, 9'h053, -1, 0);

`ifdef BRUSH_ROUND_EN
    exp_q = '{0, 1, 2, 320, 321, 322, 640, 641};
`else
    exp_q = '{0, 1, 2, 320, 321, 322, 640, 641, 642};
`endif
    run_stroke("tl", 3'd3, 9'd0, 8'd0, 3'd1, 3'd1, 3'd1, -1, 0, 1'b0);
    check_stroke("tl", exp_q, 9'h049, -1, 0);

`ifdef BRUSH_ROUND_EN
    exp_q = '{76479, 76798, 76799};
`else
    exp_q = '{76478, 76479, 76798, 76799};
`endif
    run_stroke("br", 3'd3, 9'd319, 8'd239, 3'd4, 3'd0, 3'd7, -1, 0, 1'b0);
    check_stroke("br", exp_q, 9'h107, -1, 0);

    exp_q.delete();
    run_stroke("offx", 3'd2, 9'd320, 8'd10, 3'd7, 3'd7, 3'd7, -1, 0, 1'b0);
    check_stroke("offx", exp_q, 9'h1FF, -1, 0);

    // Reset in the middle of a stroke.
    @(negedge clk);
    brush_size = 3'd2; cursor_x = 9'd100; cursor_y = 8'd50;
    r_in = 3'd1; g_in = 3'd1; b_in = 3'd1; pintar = 1'b1;
    @(negedge clk);
    pintar = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_pre_we", mem_we, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_we", mem_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_addr", mem_addr, 0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_we || busy) cnt++;
    end
    check("midrst_quiet", cnt, 0);
    $display("stroke midrst: reset applied after 2 writes");

    run_stroke("again", 3'd0, 9'd10, 8'd20, 3'd7, 3'd0, 3'd3, -1, 0, 1'b0);
    exp_q = '{6410};
    check_stroke("again", exp_q, 9'h1C3, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
